fifo_serial_tx: RTL and testbench
=================================

# fifo_serial_tx

Read-side drain engine for the 4-bit nibble FIFO. It pops one nibble at a time through the FIFO read port (`read_en`/`read_data`/`empty`) and transmits each nibble on a single serial line as an asynchronous frame: start bit, 4 data bits LSB-first, optional parity, stop bit. It sits between the FIFO and the chip-level serial pin and is the consumer counterpart to whatever logic fills the FIFO.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range 2..255.
- `PARITY_EN`, default 1: 1 inserts a parity bit after the data bits; 0 omits it.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN` = 0.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  connects to the FIFO `empty` output.
- `fifo_read_data`  in  4  connects to the FIFO `read_data` output; combinational and valid in the same cycle as the pop.
- `fifo_read_en`  out  1  connects to the FIFO `read_en` input; a one-cycle pop strobe.
- `tx_enable`  in  1  permits new pops. It never aborts a frame already in progress.
- `tx_out`  out  1  serial line, registered; idle level is 1.
- `busy`  out  1  high while a frame is in flight (state ≠ IDLE).
- `frame_done`  out  1  one-cycle pulse marking frame completion.
- `sent_count`  out  8  frames completed since reset; wraps modulo 256.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx_out` = 1.
  - `fifo_read_en` = `tx_enable` & ~`fifo_empty` & ~`rst`. This is combinational from registered state.
  - On a pop, `fifo_read_data` is latched into a 4-bit shift register, parity is computed, and the next state is START.
- `fifo_read_en` is never asserted when `fifo_empty` = 1. This avoids the FIFO's empty-bypass path and guarantees a pop always returns stored data.
- START: `tx_out` = 0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: 4 bits, bit 0 first, each held `CLKS_PER_BIT` cycles. A 2-bit bit index advances; after bit 3 the next state is PARITY if `PARITY_EN`, otherwise STOP.
- PARITY: `tx_out` = XOR(data) ^ `PARITY_ODD`, held `CLKS_PER_BIT` cycles.
- STOP: `tx_out` = 1 for `CLKS_PER_BIT` cycles, then IDLE.
- Completion: on the STOP→IDLE transition, `frame_done` pulses for exactly one cycle and `sent_count` increments (255→0).
- Baud counter: width clog2(`CLKS_PER_BIT`). It reloads to 0 at every bit boundary, and a bit ends when the counter = `CLKS_PER_BIT`-1.
- `tx_enable` deasserted mid-frame: the frame completes normally, and no new pop occurs while it is low.
- `fifo_empty` rising mid-frame: no effect on the current frame.

## Timing
- Reset values, in the cycle after `rst` is sampled high:
  - `tx_out` = 1, `busy` = 0, `frame_done` = 0, `sent_count` = 0, state = IDLE.
  - `fifo_read_en` = 0 throughout while `rst` is high.
- Reset mid-frame: the same values apply on the next edge. The in-flight nibble is discarded and not re-popped.
- Let the pop be cycle T. Define F = 6 + `PARITY_EN` (bits per frame) and N = `CLKS_PER_BIT`.
  - `tx_out` = 0 from T+1 through T+N.
  - Data bit i occupies cycles T+1+(1+i)·N through T+(2+i)·N.
  - The last STOP cycle is T+F·N.
  - `frame_done` = 1 in cycle T+F·N+1, the first IDLE cycle. `busy` = 0 in that same cycle.
  - A new pop may occur in that same IDLE cycle.
- Back-to-back pops are therefore spaced F·N+1 cycles apart. This is 29 cycles at the defaults.
- `sent_count` shows its new value in the same cycle `frame_done` is high.

## Test plan
- **Reset:** hold `rst` 2 cycles with `fifo_empty` = 0 and `tx_enable` = 1 → `fifo_read_en` = 0 during reset; `tx_out` = 1, `busy` = 0, `sent_count` = 0 after reset.
- **Single frame (defaults):** FIFO holds 4'b1011; T = pop cycle.
  - `tx_out` holds 0, 1, 1, 0, 1, 1 (parity), 1 (stop), each for 4 cycles.
  - `frame_done` pulses at T+29 and `sent_count` becomes 1.
- **Parity variants:** data 4'b0000.
  - `PARITY_ODD` = 1 → parity bit 1.
  - `PARITY_ODD` = 0 → parity bit 0.
  - `PARITY_EN` = 0 → frame is 24 cycles with `frame_done` at T+25.
- **Drain 4 entries:** FIFO holds 0x1, 0x2, 0x3, 0x4 (FIFO full).
  - Exactly 4 `fifo_read_en` pulses occur, 29 cycles apart, and nibbles are transmitted in order.
  - `fifo_read_en` stays low once `fifo_empty` = 1; `sent_count` = 4.
- **Enable gating:** drop `tx_enable` during DATA of frame 1 with 2 entries queued.
  - Frame 1 completes and no pop occurs while `tx_enable` is low.
  - On re-enable, the pop occurs in the next IDLE cycle.
- **Reset mid-frame, then wrap:**
  - Assert `rst` in DATA → next cycle `tx_out` = 1, `busy` = 0.
  - Then send 256 frames → `sent_count` returns to 0 on the 256th `frame_done`.

Source files
------------

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: drains 4-bit nibbles from the FIFO read port and sends
// each one as an asynchronous serial frame on tx_out. A frame is a start
// bit, 4 data bits LSB-first, an optional parity bit and a stop bit, and
// every bit lasts CLKS_PER_BIT clock cycles.
module fifo_serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [3:0] fifo_read_data,
    output logic       fifo_read_en,
    input  logic       tx_enable,
    output logic       tx_out,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] sent_count
);

    // Baud counter runs 0..CLKS_PER_BIT-1 within each serial bit.
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] baud;
    logic [1:0]    bit_idx;
    logic [3:0]    shreg;
    logic          par_bit;
    logic          bit_end;

    // Last cycle of the current serial bit.
    assign bit_end = (baud == BAUD_LAST);

    // Pop strobe: only from IDLE, never into an empty FIFO, never in reset.
    // It is decoded from the state register so the FIFO sees it in the same
    // cycle that read_data is sampled below.
    assign fifo_read_en = (state == IDLE) & tx_enable & ~fifo_empty & ~rst;

    // Frame sequencer: every output is registered so tx_out never glitches
    // and each bit's level is presented on the edge that starts that bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            sent_count <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    baud   <= '0;
                    if (fifo_read_en) begin
                        // Latch the nibble and its parity at pop time so the
                        // FIFO is free to change read_data afterwards.
                        shreg   <= fifo_read_data;
                        par_bit <= (^fifo_read_data) ^ PARITY_ODD;
                        bit_idx <= '0;
                        tx_out  <= 1'b0;
                        busy    <= 1'b1;
                        state   <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud   <= '0;
                        tx_out <= shreg[0];
                        shreg  <= shreg >> 1;
                        state  <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == 2'd3) begin
                            if (PARITY_EN) begin
                                tx_out <= par_bit;
                                state  <= PARITY;
                            end else begin
                                tx_out <= 1'b1;
                                state  <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 2'd1;
                            tx_out  <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        baud   <= '0;
                        tx_out <= 1'b1;
                        state  <= STOP;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        // Completion is flagged in the first IDLE cycle, the
                        // same cycle in which the next pop may already occur.
                        baud       <= '0;
                        tx_out     <= 1'b1;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        sent_count <= sent_count + 8'd1;
                        state      <= IDLE;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end

                default: begin
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                    baud   <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: a queue-style FIFO feeds the default instance,
// a frame-position model predicts every output each cycle, and two extra
// instances (odd parity, no parity) are pinned with literal expectations.
module tb_fifo_serial_tx;

    localparam int N = 4;
    localparam int F = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_enable = 1'b1;
    logic       fifo_empty;
    logic [3:0] fifo_read_data;
    logic       fifo_read_en;
    logic       tx_out, busy, frame_done;
    logic [7:0] sent_count;

    logic       ren_odd, tx_odd, busy_odd, fd_odd;
    logic [7:0] cnt_odd;
    logic       ren_np, tx_np, busy_np, fd_np;
    logic [7:0] cnt_np;

    always #5 clk = ~clk;

    fifo_serial_tx dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
        .fifo_read_en(fifo_read_en), .tx_enable(tx_enable), .tx_out(tx_out),
        .busy(busy), .frame_done(frame_done), .sent_count(sent_count)
    );

    fifo_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .fifo_empty(1'b0), .fifo_read_data(4'b0000),
        .fifo_read_en(ren_odd), .tx_enable(tx_enable), .tx_out(tx_odd),
        .busy(busy_odd), .frame_done(fd_odd), .sent_count(cnt_odd)
    );

    fifo_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_np (
        .clk(clk), .rst(rst), .fifo_empty(1'b0), .fifo_read_data(4'b0000),
        .fifo_read_en(ren_np), .tx_enable(tx_enable), .tx_out(tx_np),
        .busy(busy_np), .frame_done(fd_np), .sent_count(cnt_np)
    );

    // Bench FIFO: ring of stored nibbles, popped by the DUT's strobe.
    logic [3:0] mem [0:255];
    logic [7:0] wp = 8'd0;
    logic [7:0] rp = 8'd0;
    assign fifo_empty     = (wp == rp);
    assign fifo_read_data = mem[rp];
    always @(posedge clk) if (fifo_read_en) rp <= rp + 8'd1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   failures = 0;
    int   phase = 0;
    int   probe = 0;
    logic tmo = 1'b0;

    // Model of the default instance: position within the frame.
    logic       m_known = 1'b0;
    logic       m_active = 1'b0;
    int         m_k = 0;
    logic [3:0] m_data = 4'd0;
    logic       m_fd = 1'b0;
    logic [7:0] m_cnt = 8'd0;

    int t_main = -1000;
    int t_o = -1000;
    int t_n = -1000;
    int drain_pops = 0;
    int gate_bad = 0;
    int wrap_n = 0;
    logic [6:0] pat1 = 7'b1110110;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Line level k cycles after the pop for the default configuration.
    function automatic logic exp_line(input int k, input logic [3:0] d);
        int slot;
        slot = (k - 1) / N;
        if (slot == 0) return 1'b0;
        if (slot >= 1 && slot <= 4) return d[slot-1];
        if (slot == 5) return ^d;
        return 1'b1;
    endfunction

    // Single compare process: model checks, literal pins, then model step.
    always @(negedge clk) begin
        logic e_ren;
        int   d;
        e_ren = !m_active && tx_enable && !fifo_empty && !rst;
        chk("read_en", fifo_read_en, e_ren);
        chk("timeout", tmo, 0);
        if (m_known) begin
            chk("tx_out", tx_out, m_active ? exp_line(m_k, m_data) : 1'b1);
            chk("busy", busy, m_active);
            chk("frame_done", frame_done, m_fd);
            chk("sent_count", sent_count, m_cnt);
        end

        if (phase == 1 && m_active) chk("p1_wave", tx_out, pat1[(m_k-1)/N]);
        if (phase == 1 && frame_done) begin
            chk("p1_done_at", cyc - t_main, 29);
            chk("p1_count", sent_count, 1);
        end
        if (phase == 2 && m_active && m_k > 20 && m_k <= 24) chk("even_par0", tx_out, 0);
        if (phase == 3 && fifo_read_en) begin
            if (drain_pops > 0) chk("drain_gap", cyc - t_main, 29);
            drain_pops++;
        end
        if (probe == 1) begin
            chk("drain_pops", drain_pops, 4);
            chk("drain_count", sent_count, 6);
        end
        if (phase == 4 && fifo_read_en && !tx_enable) gate_bad++;
        if (probe == 2) begin
            chk("gate_pops", gate_bad, 0);
            chk("gate_count", sent_count, 7);
        end
        if (probe == 3) chk("reenable_pop", fifo_read_en, 1);
        if (probe == 4) begin
            chk("rst_tx", tx_out, 1);
            chk("rst_busy", busy, 0);
            chk("rst_count", sent_count, 0);
        end
        if (phase == 7 && frame_done) begin
            wrap_n++;
            if (wrap_n == 255) chk("wrap_255", sent_count, 255);
            if (wrap_n == 256) chk("wrap_0", sent_count, 0);
        end
        if (probe == 5) chk("wrap_frames", wrap_n, 256);

        d = cyc - t_o;
        if (d >= 1 && d <= 4) chk("odd_start", tx_odd, 0);
        if (d >= 21 && d <= 24) chk("odd_par", tx_odd, 1);
        if (d == 29) chk("odd_done", fd_odd, 1);
        d = cyc - t_n;
        if (d >= 1 && d <= 24) chk("np_busy", busy_np, 1);
        if (d >= 17 && d <= 20) chk("np_d3", tx_np, 0);
        if (d >= 21 && d <= 24) chk("np_stop", tx_np, 1);
        if (d == 24) chk("np_done_early", fd_np, 0);
        if (d == 25) chk("np_done", fd_np, 1);

        if (fifo_read_en) t_main = cyc;
        if (ren_odd) t_o = cyc;
        if (ren_np) t_n = cyc;
        if (rst) begin
            t_o = -1000;
            t_n = -1000;
        end

        if (rst) begin
            m_known  = 1'b1;
            m_active = 1'b0;
            m_fd     = 1'b0;
            m_cnt    = 8'd0;
        end else if (m_active) begin
            if (m_k == F * N) begin
                m_active = 1'b0;
                m_fd     = 1'b1;
                m_cnt    = m_cnt + 8'd1;
            end else begin
                m_k++;
                m_fd = 1'b0;
            end
        end else begin
            m_fd = 1'b0;
            if (e_ren) begin
                m_active = 1'b1;
                m_k      = 1;
                m_data   = fifo_read_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d);
        mem[wp] = d;
        wp = wp + 8'd1;
    endtask

    task automatic flag_timeout();
        tmo = 1'b1;
        tick();
        tmo = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1;
        end
        if (seen) tick(); else flag_timeout();
    endtask

    task automatic wait_pop(input int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (fifo_read_en) seen = 1;
        end
        if (seen) tick(); else flag_timeout();
    endtask

    initial begin
        // Reset held two cycles with data waiting, then the 4'b1011 frame.
        push(4'b1011);
        phase = 1;
        tick();
        tick();
        rst = 1'b0;
        wait_done(60);

        phase = 2;
        push(4'b0000);
        wait_done(60);

        phase = 3;
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        for (int i = 0; i < 4; i++) wait_done(60);
        repeat (40) tick();
        probe = 1; tick(); probe = 0;

        phase = 4;
        push(4'h5); push(4'hA);
        wait_pop(60);
        repeat (7) tick();
        tx_enable = 1'b0;
        repeat (40) tick();
        probe = 2; tick(); probe = 0;
        tx_enable = 1'b1;
        probe = 3; tick(); probe = 0;
        wait_done(60);

        phase = 5;
        for (int i = 0; i < 800; i++) begin
            logic [7:0] occ;
            occ = wp - rp;
            tx_enable = ($urandom_range(0, 7) != 0);
            if (occ < 8'd6 && $urandom_range(0, 3) == 0) push(4'($urandom_range(0, 15)));
            tick();
        end
        tx_enable = 1'b1;
        begin
            bit idle = 0;
            for (int i = 0; i < 400 && !idle; i++) begin
                @(negedge clk);
                if (fifo_empty && !busy) idle = 1;
            end
            if (idle) tick(); else flag_timeout();
        end

        phase = 6;
        push(4'h9);
        wait_pop(60);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        probe = 4; tick(); probe = 0;

        phase = 7;
        for (int i = 0; i < 256; i++) begin
            push(4'($urandom_range(0, 15)));
            wait_done(60);
        end
        probe = 5; tick(); probe = 0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
